// File: rtl/seq_player_if.sv
// seq_player_if: playback control, pattern memory read port and LED bus.
// SEQ_PLAYER_ABORT_EN adds the abort request line.
interface seq_player_if #(
   parameter int unsigned DEPTH_BITS = 5,
   parameter int unsigned COLOR_BITS = 2
);
   logic                         start;
   logic [DEPTH_BITS:0]          length;
   logic [DEPTH_BITS-1:0]        rd_addr;
   logic [COLOR_BITS-1:0]        rd_data;
   logic [(2**COLOR_BITS)-1:0]   led;
   logic [DEPTH_BITS-1:0]        step;
   logic                         busy;
   logic                         done;
`ifdef SEQ_PLAYER_ABORT_EN
   logic                         abort;

   modport master (
      output start, length, rd_data, abort,
      input  rd_addr, led, step, busy, done
   );
   modport slave (
      input  start, length, rd_data, abort,
      output rd_addr, led, step, busy, done
   );
`else
   modport master (
      output start, length, rd_data,
      input  rd_addr, led, step, busy, done
   );
   modport slave (
      input  start, length, rd_data,
      output rd_addr, led, step, busy, done
   );
`endif
endinterface

// File: rtl/seq_player.sv
// seq_player: plays a stored colour sequence on one-hot LEDs, ON_CYCLES lit then
// OFF_CYCLES dark per step. Optional feature macro: SEQ_PLAYER_ABORT_EN (abort input).
module seq_player #(
   parameter int unsigned DEPTH_BITS = 5,
   parameter int unsigned COLOR_BITS = 2,
   parameter int unsigned CNT_WIDTH  = 26,
   parameter int unsigned ON_CYCLES  = 25000000,
   parameter int unsigned OFF_CYCLES = 12500000
) (
   input  logic           clk,
   input  logic           clr,
   seq_player_if.slave    bus
);
   localparam int unsigned LED_W = 2**COLOR_BITS;
   localparam logic [DEPTH_BITS:0] MAX_LEN = (DEPTH_BITS+1)'(2**DEPTH_BITS);
   localparam logic [CNT_WIDTH-1:0] ON_LAST  = CNT_WIDTH'(ON_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] OFF_LAST = CNT_WIDTH'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StFetch, StOn, StOff, StDone} state_t;

   state_t                state_q;
   logic [CNT_WIDTH-1:0]  counter_q;
   logic [DEPTH_BITS:0]   len_q;
   logic [DEPTH_BITS-1:0] step_q;
   logic [LED_W-1:0]      led_q;
   logic                  busy_q;
   logic                  done_q;

   logic [DEPTH_BITS:0]   len_in;
   logic                  last_step;
   logic                  abort_req;

   // Clamp requested length to memory depth; detect final step of the run.
   always_comb begin
      len_in    = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
      last_step = ({1'b0, step_q} == (len_q - 1'b1));
`ifdef SEQ_PLAYER_ABORT_EN
      abort_req = bus.abort;
`else
      abort_req = 1'b0;
`endif
   end

   // Playback FSM; all outputs are registered here.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= StIdle;
         counter_q <= '0;
         len_q     <= '0;
         step_q    <= '0;
         led_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_req && (state_q inside {StFetch, StOn, StOff})) begin
            // Abort wins over counter expiry.
            led_q     <= '0;
            counter_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.start) begin
                     len_q     <= len_in;
                     step_q    <= '0;
                     counter_q <= '0;
                     if (len_in == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                     end
                  end
               end
               StFetch: begin
                  // rd_addr has been stable on step_q for this whole cycle.
                  led_q     <= LED_W'(1) << bus.rd_data;
                  counter_q <= '0;
                  state_q   <= StOn;
               end
               StOn: begin
                  if (counter_q == ON_LAST) begin
                     led_q     <= '0;
                     counter_q <= '0;
                     state_q   <= StOff;
                  end else begin
                     counter_q <= counter_q + 1'b1;
                  end
               end
               StOff: begin
                  if (counter_q == OFF_LAST) begin
                     counter_q <= '0;
                     if (last_step) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        step_q  <= step_q + 1'b1;
                        state_q <= StFetch;
                     end
                  end else begin
                     counter_q <= counter_q + 1'b1;
                  end
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.led     = led_q;
   assign bus.rd_addr = step_q;
   assign bus.step    = step_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed vectors for seq_player with ON_CYCLES=3, OFF_CYCLES=2.
module tb_seq_player;
   localparam int unsigned DB = 5;
   localparam int unsigned CB = 2;

   logic clk;
   logic clr;
   logic [1:0] mem [32];
   int n_vec;
   int n_err;

   seq_player_if #(.DEPTH_BITS(DB), .COLOR_BITS(CB)) bus ();

   seq_player #(
      .DEPTH_BITS(DB),
      .COLOR_BITS(CB),
      .CNT_WIDTH (26),
      .ON_CYCLES (3),
      .OFF_CYCLES(2)
   ) u_dut (
      .clk(clk),
      .clr(clr),
      .bus(bus.slave)
   );

   // Combinational memory model addressed by the registered rd_addr.
   assign bus.rd_data = mem[bus.rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected per-cycle LED for memory {2,0,3}, cycle 0 = FETCH of step 0.
   logic [3:0] exp_led3 [18] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0,
                                 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};

   task automatic run_full(input logic [5:0] len, input string nm);
      bus.start  = 1'b1;
      bus.length = len;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c <= 193; c++) begin
         if (c > 0) @(negedge clk);
         if (c < 192) begin
            check({nm, "_busy"}, 32'(bus.busy), 32'd1);
            if (c % 6 == 0) check({nm, "_addr"}, 32'(bus.rd_addr), 32'(c / 6));
            if (c % 6 == 2) check({nm, "_led"}, 32'(bus.led), 32'(4'b0001 << mem[c / 6]));
         end else if (c == 192) begin
            check({nm, "_done"}, 32'(bus.done), 32'd1);
            check({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
            check({nm, "_last_step"}, 32'(bus.step), 32'd31);
         end else begin
            check({nm, "_done_clr"}, 32'(bus.done), 32'd0);
         end
      end
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      clr        = 1'b1;
      bus.start  = 1'b0;
      bus.length = '0;
`ifdef SEQ_PLAYER_ABORT_EN
      bus.abort  = 1'b0;
`endif
      for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      repeat (3) @(negedge clk);
      check("rst_led", 32'(bus.led), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_step", 32'(bus.step), 32'd0);
      clr = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of step 1's ON phase.
      bus.start  = 1'b1;
      bus.length = 6'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_led", 32'(bus.led), 32'h1);
      check("mid_step", 32'(bus.step), 32'd1);
      clr = 1'b1;
      #1;
      check("arst_led", 32'(bus.led), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_step", 32'(bus.step), 32'd0);
      check("arst_addr", 32'(bus.rd_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("post_rst_done", 32'(bus.done), 32'd0);
         check("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      // Three-step sequence {2,0,3}.
      bus.start  = 1'b1;
      bus.length = 6'd3;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c <= 19; c++) begin
         if (c > 0) @(negedge clk);
         if (c < 18) begin
            check("seq3_led", 32'(bus.led), 32'(exp_led3[c]));
            check("seq3_busy", 32'(bus.busy), 32'd1);
            check("seq3_step", 32'(bus.step), 32'(c / 6));
            check("seq3_done", 32'(bus.done), 32'd0);
         end else begin
            check("seq3_led_end", 32'(bus.led), 32'd0);
            check("seq3_busy_end", 32'(bus.busy), 32'd0);
            check("seq3_done_end", 32'(bus.done), (c == 18) ? 32'd1 : 32'd0);
         end
      end

      // Zero length: done next cycle, never busy.
      bus.start  = 1'b1;
      bus.length = 6'd0;
      @(negedge clk);
      bus.start = 1'b0;
      check("len0_done", 32'(bus.done), 32'd1);
      check("len0_busy", 32'(bus.busy), 32'd0);
      check("len0_led", 32'(bus.led), 32'd0);
      @(negedge clk);
      check("len0_done_clr", 32'(bus.done), 32'd0);
      check("len0_busy2", 32'(bus.busy), 32'd0);

      // Full depth and clamped over-length.
      for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
      run_full(6'd32, "full32");
      run_full(6'd33, "full33");

      // start held high, length changed mid-run, back-to-back restart.
      mem[0] = 2'd1; mem[1] = 2'd2;
      bus.start  = 1'b1;
      bus.length = 6'd2;
      @(negedge clk);
      for (int c = 0; c <= 21; c++) begin
         if (c > 0) @(negedge clk);
         if (c < 12) begin
            check("hold_busy", 32'(bus.busy), 32'd1);
            check("hold_step", 32'(bus.step), 32'(c / 6));
            check("hold_done", 32'(bus.done), 32'd0);
         end else if (c == 12) begin
            check("hold_done_end", 32'(bus.done), 32'd1);
            check("hold_busy_end", 32'(bus.busy), 32'd0);
         end else if (c == 13) begin
            check("b2b_idle_busy", 32'(bus.busy), 32'd0);
            check("b2b_idle_done", 32'(bus.done), 32'd0);
         end else if (c < 20) begin
            check("b2b_busy", 32'(bus.busy), 32'd1);
            check("b2b_step", 32'(bus.step), 32'd0);
         end else if (c == 20) begin
            check("b2b_done", 32'(bus.done), 32'd1);
         end else begin
            check("b2b_done_clr", 32'(bus.done), 32'd0);
         end
         if (c == 3)  bus.length = 6'd5;
         if (c == 12) bus.length = 6'd1;
         if (c == 14) bus.start = 1'b0;
      end
      check("b2b_led_step0", 32'(bus.led), 32'd0);

`ifdef SEQ_PLAYER_ABORT_EN
      // Abort in IDLE does nothing.
      bus.abort = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("abort_idle_busy", 32'(bus.busy), 32'd0);
         check("abort_idle_done", 32'(bus.done), 32'd0);
      end
      bus.abort = 1'b0;
      // Abort during step 1's ON phase.
      mem[0] = 2'd3; mem[1] = 2'd1; mem[2] = 2'd2;
      bus.start  = 1'b1;
      bus.length = 6'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      check("abort_pre_led", 32'(bus.led), 32'h2);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_led", 32'(bus.led), 32'd0);
      check("abort_done", 32'(bus.done), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("abort_done_clr", 32'(bus.done), 32'd0);
      check("abort_busy2", 32'(bus.busy), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
